// File: rtl/hpdmc_refresh.sv
// SDRAM auto-refresh sequencer.
// An interval counter produces refresh ticks that accumulate in an owed-refresh
// counter. When refreshes are owed, the block holds off the datapath, waits for
// it to go idle, precharges all banks and issues AUTO REFRESH commands back to
// back until the backlog is cleared. All outputs are registered from the
// next-state decode, so a command appears in the same cycle the FSM is in it.
module hpdmc_refresh (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sdram_rst,
  input  logic        bypass,
  input  logic [2:0]  tim_rp,
  input  logic [3:0]  tim_rfc,
  input  logic [10:0] tim_refi,
  input  logic        idle,
  output logic        hold,
  output logic        ref_cs_n,
  output logic        ref_ras_n,
  output logic        ref_cas_n,
  output logic        ref_we_n,
  output logic        ref_a10,
  output logic [2:0]  ref_pending,
  output logic        ref_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_PRECHARGE, S_WAIT_RP, S_REFRESH, S_WAIT_RFC
  } state_e;

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  state_e      state_q, state_d;
  logic [10:0] refi_q, refi_d;
  logic [3:0]  wait_q, wait_d;
  logic [2:0]  pending_q, pending_d;
  logic        ovf_q, ovf_d;
  logic        hold_q, hold_d;
  logic [3:0]  cmd_q, cmd_d;
  logic        a10_q, a10_d;

  logic active, tick, do_ref;

  assign active = ~sdram_rst & ~bypass;
  assign tick   = active & (refi_q == '0);
  assign do_ref = (state_q == S_REFRESH);

  // Interval counter: reload while inactive or on expiry, else count down
  always_comb begin
    refi_d = refi_q - 11'd1;
    if (!active || refi_q == '0) refi_d = tim_refi;
  end

  // Owed-refresh bookkeeping; a tick that cannot be recorded marks overflow
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (!active) begin
      pending_d = '0;
    end else if (tick && !do_ref) begin
      if (pending_q == 3'd7) ovf_d = 1'b1;
      else                   pending_d = pending_q + 3'd1;
    end else if (!tick && do_ref) begin
      pending_d = pending_q - 3'd1;
    end
  end

  // FSM state register and all registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      refi_q    <= tim_refi;
      wait_q    <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      hold_q    <= 1'b0;
      cmd_q     <= CMD_NOP;
      a10_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      refi_q    <= refi_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      hold_q    <= hold_d;
      cmd_q     <= cmd_d;
      a10_q     <= a10_d;
    end
  end

  // Next-state decode; wait counters load tim_* on entry so later changes
  // to the timing inputs do not disturb a wait already in progress.
  // Back-to-back decisions use the owed count as it will be after this edge.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:      if (pending_q != '0) state_d = S_WAIT_IDLE;
        S_WAIT_IDLE: if (idle) state_d = S_PRECHARGE;
        S_PRECHARGE: begin
          if (tim_rp == '0) begin
            state_d = S_REFRESH;
          end else begin
            state_d = S_WAIT_RP;
            wait_d  = {1'b0, tim_rp} - 4'd1;
          end
        end
        S_WAIT_RP: begin
          if (wait_q == '0) state_d = S_REFRESH;
          else              wait_d  = wait_q - 4'd1;
        end
        S_REFRESH: begin
          if (tim_rfc == '0) begin
            state_d = (pending_d != '0) ? S_REFRESH : S_IDLE;
          end else begin
            state_d = S_WAIT_RFC;
            wait_d  = tim_rfc - 4'd1;
          end
        end
        S_WAIT_RFC: begin
          if (wait_q == '0) state_d = (pending_d != '0) ? S_REFRESH : S_IDLE;
          else              wait_d  = wait_q - 4'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so commands line up with the state
  always_comb begin
    cmd_d  = CMD_NOP;
    a10_d  = 1'b0;
    hold_d = (state_d != S_IDLE);
    case (state_d)
      S_PRECHARGE: begin cmd_d = CMD_PRE; a10_d = 1'b1; end
      S_REFRESH:   cmd_d = CMD_REF;
      default:     ;
    endcase
  end

  assign hold         = hold_q;
  assign ref_cs_n     = cmd_q[3];
  assign ref_ras_n    = cmd_q[2];
  assign ref_cas_n    = cmd_q[1];
  assign ref_we_n     = cmd_q[0];
  assign ref_a10      = a10_q;
  assign ref_pending  = pending_q;
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_hpdmc_refresh.sv
// Bench for hpdmc_refresh: directed timing scenarios plus a randomized run
// against a cycle-level reference model built on owed-count arithmetic.
module tb_hpdmc_refresh;

  logic        sys_clk = 1'b0;
  logic        sys_rst, sdram_rst, bypass, idle;
  logic [2:0]  tim_rp;
  logic [3:0]  tim_rfc;
  logic [10:0] tim_refi;
  logic        hold, ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n, ref_a10, ref_overflow;
  logic [2:0]  ref_pending;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] NOP = 4'b1111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  hpdmc_refresh dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sdram_rst(sdram_rst), .bypass(bypass),
    .tim_rp(tim_rp), .tim_rfc(tim_rfc), .tim_refi(tim_refi), .idle(idle),
    .hold(hold), .ref_cs_n(ref_cs_n), .ref_ras_n(ref_ras_n), .ref_cas_n(ref_cas_n),
    .ref_we_n(ref_we_n), .ref_a10(ref_a10), .ref_pending(ref_pending),
    .ref_overflow(ref_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  logic [3:0] cmd;
  assign cmd = {ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n};

  task automatic clk1();
    @(posedge sys_clk);
    #1;
  endtask

  // Leaves the bench just after the last reset edge; the next edge is the
  // first active one.
  task automatic apply_reset();
    sys_rst = 1'b1;
    clk1();
    clk1();
    sys_rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_WI = 1, P_PRE = 2, P_RP = 3, P_REF = 4, P_RFC = 5;
  int m_cnt, m_pend, m_phase, m_left;
  bit m_ovf;

  // Predicts the state after the coming edge from the inputs now applied.
  task automatic model_step();
    int np;
    int t;
    if (sys_rst) begin
      m_cnt = int'(tim_refi); m_pend = 0; m_ovf = 0; m_phase = P_IDLE; m_left = 0;
    end else if (sdram_rst || bypass) begin
      m_cnt = int'(tim_refi); m_pend = 0; m_phase = P_IDLE;
    end else begin
      t = (m_cnt == 0) ? 1 : 0;
      m_cnt = (t == 1) ? int'(tim_refi) : m_cnt - 1;
      np = m_pend + t - ((m_phase == P_REF) ? 1 : 0);
      if (np > 7) begin np = 7; m_ovf = 1; end
      case (m_phase)
        P_IDLE: if (m_pend != 0) m_phase = P_WI;
        P_WI:   if (idle) m_phase = P_PRE;
        P_PRE: begin
          m_left = int'(tim_rp);
          m_phase = (m_left == 0) ? P_REF : P_RP;
        end
        P_RP: begin
          m_left--;
          if (m_left == 0) m_phase = P_REF;
        end
        P_REF: begin
          m_left = int'(tim_rfc);
          if (m_left == 0) m_phase = (np != 0) ? P_REF : P_IDLE;
          else             m_phase = P_RFC;
        end
        default: begin
          m_left--;
          if (m_left == 0) m_phase = (np != 0) ? P_REF : P_IDLE;
        end
      endcase
      m_pend = np;
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [3:0] c;
    logic       a;
    c = NOP; a = 1'b0;
    if (m_phase == P_PRE) begin c = PRE; a = 1'b1; end
    if (m_phase == P_REF) c = REF;
    return {(m_phase != P_IDLE), c, a, m_pend[2:0], m_ovf};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    tim_refi = 11'd9; tim_rp = 3'd2; tim_rfc = 4'd3; idle = 1'b1;
    sdram_rst = 1'b0; bypass = 1'b0;
    apply_reset();
    n_checks++;
    if ({hold, cmd, ref_a10, ref_pending, ref_overflow} !== {1'b0, NOP, 1'b0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got hold=%b cmd=%b a10=%b pend=%0d ovf=%b, want 0 1111 0 0 0",
               hold, cmd, ref_a10, ref_pending, ref_overflow);
    end
  endtask

  task automatic test_basic();
    int rise, pre, rf, fall;
    logic pre_a10;
    rise = -1; pre = -1; rf = -1; fall = -1; pre_a10 = 1'b0;
    tim_refi = 11'd9; tim_rp = 3'd2; tim_rfc = 4'd3; idle = 1'b1;
    apply_reset();
    for (int c = 1; c <= 19; c++) begin
      clk1();
      if (hold && rise < 0) rise = c;
      if (cmd == PRE && pre < 0) begin pre = c; pre_a10 = ref_a10; end
      if (cmd == REF && rf < 0) rf = c;
      if (!hold && rise > 0 && fall < 0) fall = c;
    end
    n_checks++;
    if (rise !== 11) begin n_fail++; $display("FAIL basic_hold_rise: got cycle %0d want 11", rise); end
    n_checks++;
    if (pre !== 12 || pre_a10 !== 1'b1) begin
      n_fail++; $display("FAIL basic_precharge: got cycle %0d a10=%b want 12 a10=1", pre, pre_a10);
    end
    n_checks++;
    if (rf !== 15) begin n_fail++; $display("FAIL basic_refresh: got cycle %0d want 15", rf); end
    n_checks++;
    if (fall !== 19) begin n_fail++; $display("FAIL basic_hold_fall: got cycle %0d want 19", fall); end
  endtask

  task automatic test_backlog();
    int non_nop, npre, nref;
    int refs[$];
    non_nop = 0; npre = 0; nref = 0;
    tim_refi = 11'd9; tim_rp = 3'd2; tim_rfc = 4'd3; idle = 1'b0;
    apply_reset();
    for (int c = 1; c <= 40; c++) begin
      clk1();
      if (cmd != NOP) non_nop++;
      if (c == 9) begin
        n_checks++;
        if (ref_pending !== 3'd0) begin n_fail++; $display("FAIL tick_before: got %0d want 0", ref_pending); end
      end
      if (c == 10) begin
        n_checks++;
        if (ref_pending !== 3'd1) begin n_fail++; $display("FAIL tick_period: got %0d want 1", ref_pending); end
      end
      if (c == 30) tim_refi = 11'd2000;
    end
    n_checks++;
    if (non_nop !== 0 || ref_pending !== 3'd4) begin
      n_fail++; $display("FAIL backlog_accum: got non_nop=%0d pend=%0d want 0 and 4", non_nop, ref_pending);
    end
    idle = 1'b1;
    for (int c = 41; c <= 62; c++) begin
      clk1();
      if (cmd == PRE) npre++;
      if (cmd == REF) refs.push_back(c);
    end
    nref = refs.size();
    n_checks++;
    if (npre !== 1 || nref !== 4) begin
      n_fail++; $display("FAIL backlog_counts: got pre=%0d ref=%0d want 1 and 4", npre, nref);
    end else begin
      n_checks++;
      if (refs[0] !== 44 || refs[1] !== 48 || refs[2] !== 52 || refs[3] !== 56) begin
        n_fail++; $display("FAIL backlog_spacing: got %0d %0d %0d %0d want 44 48 52 56",
                           refs[0], refs[1], refs[2], refs[3]);
      end
    end
    n_checks++;
    if (ref_pending !== 3'd0 || hold !== 1'b0) begin
      n_fail++; $display("FAIL backlog_drain: got pend=%0d hold=%b want 0 0", ref_pending, hold);
    end
  endtask

  task automatic test_overflow();
    tim_refi = 11'd9; tim_rp = 3'd2; tim_rfc = 4'd3; idle = 1'b0;
    apply_reset();
    for (int c = 1; c <= 90; c++) begin
      clk1();
      if (c == 79) begin
        n_checks++;
        if (ref_overflow !== 1'b0 || ref_pending !== 3'd7) begin
          n_fail++; $display("FAIL ovf_early: got ovf=%b pend=%0d want 0 7", ref_overflow, ref_pending);
        end
      end
      if (c == 80) begin
        n_checks++;
        if (ref_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ref_overflow); end
        tim_refi = 11'd2000;
      end
    end
    n_checks++;
    if (ref_pending !== 3'd7) begin n_fail++; $display("FAIL ovf_saturate: got %0d want 7", ref_pending); end
    idle = 1'b1;
    for (int c = 0; c < 50; c++) clk1();
    n_checks++;
    if (ref_overflow !== 1'b1 || ref_pending !== 3'd0 || hold !== 1'b0) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b pend=%0d hold=%b want 1 0 0", ref_overflow, ref_pending, hold);
    end
    sys_rst = 1'b1;
    clk1();
    sys_rst = 1'b0;
    n_checks++;
    if (ref_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_reset_clear: got %b want 0", ref_overflow); end
  endtask

  task automatic test_zero_timing();
    int pre, rf, fall;
    pre = -1; rf = -1; fall = -1;
    tim_refi = 11'd9; tim_rp = 3'd0; tim_rfc = 4'd0; idle = 1'b1;
    apply_reset();
    for (int c = 1; c <= 16; c++) begin
      clk1();
      if (cmd == PRE && pre < 0) pre = c;
      if (cmd == REF && rf < 0) rf = c;
      if (!hold && rf > 0 && fall < 0) fall = c;
    end
    n_checks++;
    if (pre !== 12 || rf !== 13 || fall !== 14) begin
      n_fail++; $display("FAIL zero_timing: got pre=%0d ref=%0d fall=%0d want 12 13 14", pre, rf, fall);
    end
  endtask

  task automatic test_bypass_abort();
    int nref;
    nref = 0;
    tim_refi = 11'd9; tim_rp = 3'd5; tim_rfc = 4'd3; idle = 1'b1;
    apply_reset();
    for (int c = 1; c <= 20; c++) begin
      clk1();
      if (cmd == REF) nref++;
      if (c == 14) bypass = 1'b1;
      if (c == 15) begin
        n_checks++;
        if (hold !== 1'b0 || cmd !== NOP || ref_a10 !== 1'b0 || ref_pending !== 3'd0) begin
          n_fail++; $display("FAIL bypass_abort: got hold=%b cmd=%b pend=%0d want 0 1111 0", hold, cmd, ref_pending);
        end
      end
    end
    n_checks++;
    if (nref !== 0) begin n_fail++; $display("FAIL bypass_no_refresh: got %0d refreshes want 0", nref); end
    bypass = 1'b0;
  endtask

  task automatic test_tick_coincident();
    int rf2, fall;
    rf2 = -1; fall = -1;
    tim_refi = 11'd9; tim_rp = 3'd6; tim_rfc = 4'd3; idle = 1'b1;
    apply_reset();
    for (int c = 1; c <= 28; c++) begin
      clk1();
      if (c == 19) begin
        n_checks++;
        if (cmd !== REF) begin n_fail++; $display("FAIL coinc_first_ref: got cmd=%b want 0001", cmd); end
      end
      if (c == 20) begin
        n_checks++;
        if (ref_pending !== 3'd1 || ref_overflow !== 1'b0) begin
          n_fail++; $display("FAIL coinc_pending: got pend=%0d ovf=%b want 1 0", ref_pending, ref_overflow);
        end
      end
      if (c > 19 && cmd == REF && rf2 < 0) rf2 = c;
      if (c > 19 && !hold && fall < 0) fall = c;
    end
    n_checks++;
    if (rf2 !== 23 || fall !== 27) begin
      n_fail++; $display("FAIL coinc_second_ref: got ref=%0d fall=%0d want 23 27", rf2, fall);
    end
  endtask

  task automatic test_random();
    logic [9:0] exp, got;
    int shown;
    shown = 0;
    for (int it = 0; it < 8; it++) begin
      tim_refi = 11'($urandom_range(0, 20));
      tim_rp   = 3'($urandom_range(0, 7));
      tim_rfc  = 4'($urandom_range(0, 15));
      sdram_rst = 1'b0; bypass = 1'b0; idle = 1'b1;
      sys_rst = 1'b1;
      for (int c = 0; c < 400; c++) begin
        model_step();
        clk1();
        exp = model_out();
        got = {hold, cmd, ref_a10, ref_pending, ref_overflow};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random it=%0d cyc=%0d: got %b want %b (hold,cmd,a10,pend,ovf)", it, c, got, exp);
          end
        end
        sys_rst   = ($urandom_range(0, 299) == 0);
        sdram_rst = ($urandom_range(0, 79) == 0);
        bypass    = ($urandom_range(0, 59) == 0);
        idle      = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) tim_rp   = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 39) == 0) tim_rfc  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 39) == 0) tim_refi = 11'($urandom_range(0, 20));
      end
    end
    sys_rst = 1'b0; sdram_rst = 1'b0; bypass = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1; sdram_rst = 1'b0; bypass = 1'b0; idle = 1'b1;
    tim_rp = 3'd2; tim_rfc = 4'd3; tim_refi = 11'd9;
    test_reset();
    test_basic();
    test_backlog();
    test_overflow();
    test_zero_timing();
    test_bypass_abort();
    test_tick_coincident();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdmc_refresh.md
HPDMC_REFRESH -- requirements
Module: hpdmc_refresh

Interface
REQ-001 SHALL have ports: sys_clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: sys_rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: sdram_rst  in  1  control-interface SDRAM reset hold; 1 = block inactive.
REQ-004 SHALL have ports: bypass  in  1  software owns the SDRAM bus; 1 = block inactive.
REQ-005 SHALL have ports: tim_rp  in  3  NOP cycles after PRECHARGE.
REQ-006 SHALL have ports: tim_rfc  in  4  NOP cycles after AUTO REFRESH.
REQ-007 SHALL have ports: tim_refi  in  11  refresh interval in cycles.
REQ-008 SHALL have ports: idle  in  1  datapath has no transfer in flight; it must not start one while hold=1.
REQ-009 SHALL have ports: hold  out  1  blocks new datapath accesses.
REQ-010 SHALL have ports: ref_cs_n, ref_ras_n, ref_cas_n, ref_we_n  out  1 each  SDRAM command, registered.
REQ-011 SHALL have ports: ref_a10  out  1  address bit 10, 1 = precharge all banks.
REQ-012 SHALL have ports: ref_pending  out  3  owed refreshes.
REQ-013 SHALL have ports: ref_overflow  out  1  sticky, set when a refresh is lost.

Function
REQ-014 Active SHALL mean sdram_rst=0 and bypass=0; all outputs SHALL be registered.
REQ-015 While inactive: interval counter reloads tim_refi each cycle, pending=0, FSM forced to IDLE, hold=0, command=NOP; ref_overflow SHALL be retained.
REQ-016 Interval counter, active: decrement by 1 per cycle. At 0 it SHALL emit a one-cycle tick and reload tim_refi, giving a period of tim_refi+1 cycles.
REQ-017 On a tick, pending SHALL increment, saturating at 7; a tick at pending=7 SHALL leave pending at 7 and set ref_overflow.
REQ-018 Tick and refresh issue in the same cycle SHALL leave pending unchanged; ref_overflow SHALL NOT set in that case.
REQ-019 NOP SHALL be cs_n=1, ras_n=1, cas_n=1, we_n=1, a10=0.
REQ-020 FSM states SHALL be IDLE, WAIT_IDLE, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC.
REQ-021 IDLE: if pending!=0, go to WAIT_IDLE and set hold=1 on the same edge.
REQ-022 WAIT_IDLE: hold=1; when idle=1 is sampled, go to PRECHARGE.
REQ-023 PRECHARGE: drive cs_n=0, ras_n=0, cas_n=1, we_n=0, a10=1 for exactly one cycle.
REQ-024 WAIT_RP: NOP for exactly tim_rp cycles; with tim_rp=0, REFRESH SHALL follow PRECHARGE directly.
REQ-025 Timing: PRECHARGE at cycle T SHALL place REFRESH at cycle T+1+tim_rp.
REQ-026 REFRESH: drive cs_n=0, ras_n=0, cas_n=0, we_n=1, a10=0 for one cycle; pending SHALL decrement on that cycle.
REQ-027 WAIT_RFC: NOP for exactly tim_rfc cycles.
REQ-028 End of WAIT_RFC with pending!=0: go straight to REFRESH, hold kept 1, no second PRECHARGE.
REQ-029 End of WAIT_RFC with pending=0: go to IDLE and drop hold to 0 at cycle U+1+tim_rfc, where U is the last REFRESH cycle.
REQ-030 tim_* SHALL be sampled when each counter loads; changes during an in-progress wait SHALL NOT alter that wait.
REQ-031 Going inactive mid-sequence SHALL abort at the next edge with no partial command held and no further command issued.

Reset
REQ-032 On sys_rst=1: FSM=IDLE, hold=0, command=NOP, ref_pending=0, ref_overflow=0, interval counter=tim_refi.
REQ-033 Reset SHALL take priority over every other condition.

Verification
REQ-034 Scenario: tim_refi=9, tim_rp=2, tim_rfc=3, idle=1 -> hold rises 11 cycles after activation; PRECHARGE a10=1 on the next cycle; REFRESH 3 cycles later; hold falls 4 cycles after REFRESH.
REQ-035 Scenario: idle=0 for 40 cycles with tim_refi=9 -> pending counts to 4, command stays NOP throughout; on idle=1, one PRECHARGE then 4 REFRESH commands spaced tim_rfc+1 apart; pending ends at 0.
REQ-036 Scenario: idle held 0 for 9 ticks -> pending saturates at 7 and ref_overflow=1; ref_overflow stays 1 after the backlog drains; sys_rst clears it.
REQ-037 Scenario: tim_rp=0, tim_rfc=0 -> REFRESH on the cycle after PRECHARGE; hold falls the cycle after REFRESH.
REQ-038 Scenario: bypass set to 1 during WAIT_RP -> next cycle hold=0, command NOP, pending=0; no REFRESH issued.
REQ-039 Scenario: tick coincident with REFRESH at pending=1 -> pending stays 1 and a further REFRESH follows after tim_rfc.
